// File: rtl/map_merger_pkg.sv
// map_merger_pkg: shared state encoding, lane count and int8 saturation limits.
package map_merger_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  localparam int LANES = 4;
  localparam logic signed [7:0] INT8_MAX = 8'sh7f;
  localparam logic signed [7:0] INT8_MIN = 8'sh80;
  localparam logic signed [32:0] SAT_MAX = 33'sd127;
  localparam logic signed [32:0] SAT_MIN = -33'sd128;
endpackage

// File: rtl/map_merger_quant.sv
// map_merger_quant: bias add, optional ReLU, floor shift and int8 saturation of one psum.
module map_merger_quant
  import map_merger_pkg::*;
(
  input  logic [31:0] psum_i,
  input  logic [31:0] bias_i,
  input  logic [4:0]  shift_i,
  input  logic        relu_en_i,
  output logic [7:0]  q_o
);
  logic signed [32:0] s, r, sh;
  // 33 bits so psum + bias can never wrap
  assign s  = $signed({psum_i[31], psum_i}) + $signed({bias_i[31], bias_i});
  assign r  = (relu_en_i && s[32]) ? '0 : s;
  assign sh = r >>> shift_i;
  assign q_o = sh > SAT_MAX ? INT8_MAX : sh < SAT_MIN ? INT8_MIN : sh[7:0];
endmodule

// File: rtl/map_merger.sv
// map_merger: packs four beats of two requantised psums into 64-bit int8 words
// and streams them to the output buffer at consecutive addresses.
module map_merger
  import map_merger_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [15:0]       cfg_len,
  input  logic [31:0]       cfg_bias,
  input  logic [4:0]        cfg_shift,
  input  logic              cfg_relu_en,
  input  logic [63:0]       psum_acc2map_merger_data,
  input  logic              psum_acc2map_merger_vld,
  output logic              psum_acc2map_merger_rdy,
  output logic [ADDR_W-1:0] map_merger2obuf_addr,
  output logic [63:0]       map_merger2obuf_data,
  output logic              map_merger2obuf_vld,
  input  logic              map_merger2obuf_rdy,
  output logic              busy,
  output logic              done
);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d;
  logic [15:0] len_q, len_d, issued_q, issued_d, hs_q, hs_d;
  logic [31:0] bias_q, bias_d;
  logic [4:0]  shift_q, shift_d;
  logic        relu_q, relu_d, vld_q, vld_d, done_q, done_d;
  logic [1:0]  lane_q, lane_d;
  logic [47:0] acc_q, acc_d;
  logic [63:0] data_q, data_d;
  logic [7:0]  q_lo, q_hi;
  logic        run, beat, out_hs;

  map_merger_quant u_quant_lo (.psum_i(psum_acc2map_merger_data[31:0]), .bias_i(bias_q),
    .shift_i(shift_q), .relu_en_i(relu_q), .q_o(q_lo));
  map_merger_quant u_quant_hi (.psum_i(psum_acc2map_merger_data[63:32]), .bias_i(bias_q),
    .shift_i(shift_q), .relu_en_i(relu_q), .q_o(q_hi));

  assign run    = state_q == RUN;
  // the word-completing beat needs the output register free (or freeing this cycle)
  assign psum_acc2map_merger_rdy = run && (lane_q != 2'(LANES - 1) || !vld_q || map_merger2obuf_rdy)
                                   && issued_q < len_q;
  assign beat   = psum_acc2map_merger_vld && psum_acc2map_merger_rdy;
  assign out_hs = vld_q && map_merger2obuf_rdy;
  assign map_merger2obuf_addr = addr_q;
  assign map_merger2obuf_data = data_q;
  assign map_merger2obuf_vld  = vld_q;
  assign busy = run;
  assign done = done_q;

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    bias_d   = bias_q;
    shift_d  = shift_q;
    relu_d   = relu_q;
    lane_d   = lane_q;
    issued_d = issued_q;
    hs_d     = hs_q;
    acc_d    = acc_q;
    data_d   = data_q;
    addr_d   = addr_q;
    vld_d    = vld_q;
    done_d   = 1'b0;
    if (state_q == IDLE) begin
      if (cfg_start) begin
        base_d   = cfg_base_addr;
        len_d    = cfg_len;
        bias_d   = cfg_bias;
        shift_d  = cfg_shift;
        relu_d   = cfg_relu_en;
        lane_d   = '0;
        issued_d = '0;
        hs_d     = '0;
        state_d  = cfg_len != 16'd0 ? RUN : IDLE;
        done_d   = cfg_len == 16'd0;
      end
    end else begin
      if (out_hs) begin
        vld_d = 1'b0;
        hs_d  = hs_q + 16'd1;
        if (hs_q == len_q - 16'd1) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      if (beat) begin
        lane_d = lane_q + 2'd1;
        if (lane_q == 2'(LANES - 1)) begin
          data_d   = {q_hi, q_lo, acc_q};
          addr_d   = base_q + ADDR_W'({issued_q, 3'b000});
          vld_d    = 1'b1;
          issued_d = issued_q + 16'd1;
        end else acc_d[{lane_q, 4'b0000} +: 16] = {q_hi, q_lo};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      base_q   <= '0;
      len_q    <= '0;
      bias_q   <= '0;
      shift_q  <= '0;
      relu_q   <= 1'b0;
      lane_q   <= '0;
      issued_q <= '0;
      hs_q     <= '0;
      acc_q    <= '0;
      data_q   <= '0;
      addr_q   <= '0;
      vld_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      len_q    <= len_d;
      bias_q   <= bias_d;
      shift_q  <= shift_d;
      relu_q   <= relu_d;
      lane_q   <= lane_d;
      issued_q <= issued_d;
      hs_q     <= hs_d;
      acc_q    <= acc_d;
      data_q   <= data_d;
      addr_q   <= addr_d;
      vld_q    <= vld_d;
      done_q   <= done_d;
    end
  end
endmodule

// File: tb/tb_map_merger.sv
// tb_map_merger: table vectors, directed corner sequences and randomized maps
// checked against an arithmetic reference model.
module tb_map_merger;
  logic        clk = 0, rst_n = 0, cfg_start = 0, cfg_relu_en = 0;
  logic [31:0] cfg_base_addr = '0, cfg_bias = '0;
  logic [15:0] cfg_len = '0;
  logic [4:0]  cfg_shift = '0;
  logic [63:0] in_data = '0;
  logic        in_vld = 0, in_rdy, obuf_vld, obuf_rdy = 1, busy, done;
  logic [31:0] obuf_addr;
  logic [63:0] obuf_data;

  int n_tests = 0, n_fail = 0, cyc = 0, last_hs = 0, mode = 0, stall_n = 0;
  logic [31:0] got_a[$];
  logic [63:0] got_d[$];
  logic [31:0] ps_q[$];

  typedef struct packed {
    logic [31:0]       bias;
    logic [4:0]        shift;
    logic              relu;
    logic [7:0][31:0]  ps;
    logic [63:0]       exp;
  } vec_t;
  vec_t vt[7];

  map_merger #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr),
    .cfg_len(cfg_len), .cfg_bias(cfg_bias), .cfg_shift(cfg_shift), .cfg_relu_en(cfg_relu_en),
    .psum_acc2map_merger_data(in_data), .psum_acc2map_merger_vld(in_vld),
    .psum_acc2map_merger_rdy(in_rdy), .map_merger2obuf_addr(obuf_addr),
    .map_merger2obuf_data(obuf_data), .map_merger2obuf_vld(obuf_vld),
    .map_merger2obuf_rdy(obuf_rdy), .busy(busy), .done(done));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got timeout expected event", nm);
  endtask

  function automatic logic [7:0] model_q(input logic [31:0] p, input logic [31:0] b,
                                         input logic [4:0] sh, input logic r);
    longint s;
    s = longint'($signed(p)) + longint'($signed(b));
    if (r && s < 0) s = 0;
    s = s >>> sh;
    if (s > 127) return 8'h7f;
    if (s < -128) return 8'h80;
    return s[7:0];
  endfunction

  function automatic logic [31:0] rnd_ps();
    return ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 2000)) - 32'd1000;
  endfunction

  // output buffer ready: always, random, or a 5-cycle stall on the word at 0x1008
  always @(posedge clk) begin
    #1;
    if (mode == 1) obuf_rdy = 1'($urandom_range(0, 1));
    else if (mode == 2 && obuf_vld && obuf_addr == 32'h1008 && stall_n < 5) begin
      obuf_rdy = 0;
      stall_n++;
    end else obuf_rdy = 1;
  end

  logic pv = 0, pr = 0;
  logic [31:0] pa = '0;
  logic [63:0] pd = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (pv && !pr) begin
        chk("hold_vld", obuf_vld, 1);
        chk("hold_addr", obuf_addr, pa);
        chk("hold_data", obuf_data, pd);
      end
      if (obuf_vld && obuf_rdy) begin
        got_a.push_back(obuf_addr);
        got_d.push_back(obuf_data);
        last_hs = cyc;
      end
    end
    pv = obuf_vld && rst_n;
    pr = obuf_rdy;
    pa = obuf_addr;
    pd = obuf_data;
  end

  task automatic run(input logic [31:0] base, input logic [15:0] len, input logic [31:0] bias,
                     input logic [4:0] sh, input logic r, input int abort, input bit poke);
    logic [63:0] expw[$];
    logic [63:0] w;
    int to;
    for (int i = 0; i < int'(len); i++) begin
      for (int j = 0; j < 8; j++) w[8*j +: 8] = model_q(ps_q[8*i+j], bias, sh, r);
      expw.push_back(w);
    end
    got_a.delete();
    got_d.delete();
    @(posedge clk); #1;
    cfg_base_addr = base; cfg_len = len; cfg_bias = bias; cfg_shift = sh; cfg_relu_en = r;
    cfg_start = 1;
    @(posedge clk); #1;
    cfg_start = 0;
    cfg_base_addr = $urandom; cfg_len = 16'($urandom); cfg_bias = $urandom;
    cfg_shift = 5'($urandom); cfg_relu_en = ~r;
    @(negedge clk);
    if (len == 0) begin
      chk("len0_done", done, 1);
      chk("len0_busy", busy, 0);
      @(negedge clk);
      chk("len0_done_pulse", done, 0);
      chk("len0_busy2", busy, 0);
      chk("len0_words", 64'(got_d.size()), 0);
      return;
    end
    chk("busy_run", busy, 1);
    @(posedge clk); #1;
    for (int b = 0; b < 4 * int'(len); b++) begin
      if (b == abort) begin
        in_vld = 0;
        return;
      end
      in_data = {ps_q[2*b+1], ps_q[2*b]};
      in_vld = 1;
      if (poke) begin
        cfg_start = (b == 2);
        cfg_len = 16'd0;
      end
      to = 0;
      forever begin
        @(negedge clk);
        chk("in_rdy", in_rdy, !((b % 4 == 3) && obuf_vld && !obuf_rdy));
        if (in_rdy) break;
        if (++to > 200) begin
          fail_now("rdy_timeout");
          in_vld = 0;
          return;
        end
        @(posedge clk); #1;
      end
      @(posedge clk); #1;
    end
    cfg_start = 0;
    in_data = 64'hDEAD_BEEF_0BAD_F00D;
    to = 0;
    forever begin
      @(negedge clk);
      if (done) break;
      chk("rdy_after_last", in_rdy, 0);
      if (++to > 400) begin
        fail_now("done_timeout");
        in_vld = 0;
        return;
      end
    end
    chk("busy_at_done", busy, 0);
    chk("done_latency", 64'(cyc), 64'(last_hs + 1));
    in_vld = 0;
    chk("nwords", 64'(got_d.size()), 64'(len));
    for (int i = 0; i < got_d.size() && i < int'(len); i++) begin
      chk("addr", got_a[i], base + 32'(8 * i));
      chk("data", got_d[i], expw[i]);
    end
    @(negedge clk);
    chk("done_pulse", done, 0);
  endtask

  initial begin
    vt[0] = '{bias: 0, shift: 0, relu: 0,
              ps: {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1},
              exp: 64'h0807060504030201};
    vt[1] = '{bias: 32'd44, shift: 1, relu: 0, ps: {8{32'hFFFFFED4}}, exp: 64'h8080808080808080};
    vt[2] = '{bias: 32'd44, shift: 1, relu: 1, ps: {8{32'hFFFFFED4}}, exp: 64'h0};
    vt[3] = '{bias: 0, shift: 2, relu: 0, ps: {8{32'd1000}}, exp: 64'h7F7F7F7F7F7F7F7F};
    vt[4] = '{bias: 0, shift: 0, relu: 0,
              ps: {32'hFFFFFFFB, 32'd5, 32'hFFFFFFFF, 32'd0, 32'hFFFFFF7F, 32'hFFFFFF80, 32'd128, 32'd127},
              exp: 64'hFB05FF0080807F7F};
    vt[5] = '{bias: 0, shift: 1, relu: 0,
              ps: {32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFD},
              exp: 64'h0000000000FF01FE};
    vt[6] = '{bias: 32'h7FFFFFFF, shift: 31, relu: 0, ps: {8{32'h7FFFFFFF}}, exp: 64'h0101010101010101};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", in_rdy, 0);
    chk("rst_vld", obuf_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", obuf_addr, 0);
    chk("rst_data", obuf_data, 0);
    rst_n = 1;

    for (int i = 0; i < 7; i++) begin
      ps_q.delete();
      for (int j = 0; j < 8; j++) ps_q.push_back(vt[i].ps[j]);
      run(32'(i * 256), 16'd1, vt[i].bias, vt[i].shift, vt[i].relu, -1, 0);
      if (got_d.size() > 0) chk("vector", got_d[0], vt[i].exp);
    end

    run(32'h2000, 16'd0, 0, 0, 0, -1, 0);

    mode = 2;
    stall_n = 0;
    ps_q.delete();
    for (int j = 0; j < 24; j++) ps_q.push_back(32'($urandom_range(0, 255)) - 32'd128);
    run(32'h1000, 16'd3, 0, 0, 0, -1, 0);
    chk("stall_cycles", 64'(stall_n), 5);
    mode = 0;

    ps_q.delete();
    for (int j = 0; j < 16; j++) ps_q.push_back(rnd_ps());
    run(32'h3000, 16'd2, 32'd5, 5'd1, 1'b0, 2, 0);
    rst_n = 0;
    #1;
    chk("arst_rdy", in_rdy, 0);
    chk("arst_vld", obuf_vld, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_addr", obuf_addr, 0);
    chk("arst_data", obuf_data, 0);
    @(posedge clk); #1;
    rst_n = 1;
    run(32'h3000, 16'd2, 32'd5, 5'd1, 1'b0, -1, 0);

    mode = 1;
    for (int t = 0; t < 8; t++) begin
      logic [15:0] len;
      logic [31:0] base;
      len = 16'($urandom_range(1, 5));
      base = $urandom & 32'hFFFF_FFF8;
      ps_q.delete();
      for (int j = 0; j < 8 * int'(len); j++) ps_q.push_back(rnd_ps());
      run(base, len, 32'($urandom_range(0, 600)) - 32'd300, 5'($urandom_range(0, 8)),
          1'($urandom_range(0, 1)), -1, t == 3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/map_merger.md
MAP_MERGER -- requirements
Module: map_merger

Interface
REQ-001 Parameter ADDR_W, default 32, output-buffer byte-address width.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 cfg_start  input  1  one-cycle start pulse; sampled only in IDLE.
REQ-005 cfg_base_addr  input  ADDR_W  byte address of first output word.
REQ-006 cfg_len  input  16  number of 64-bit output words in the map.
REQ-007 cfg_bias  input  32  signed bias added to every psum.
REQ-008 cfg_shift  input  5  requantisation arithmetic right shift.
REQ-009 cfg_relu_en  input  1  enables ReLU.
REQ-010 psum_acc2map_merger_data  input  64  two signed 32-bit psums; [31:0] first, [63:32] second.
REQ-011 psum_acc2map_merger_vld  input  1  input beat valid.
REQ-012 psum_acc2map_merger_rdy  output  1  merger accepts beat.
REQ-013 map_merger2obuf_addr  output  ADDR_W  output word byte address.
REQ-014 map_merger2obuf_data  output  64  eight packed int8 results.
REQ-015 map_merger2obuf_vld  output  1  output word valid.
REQ-016 map_merger2obuf_rdy  input  1  output buffer accepts word.
REQ-017 busy  output  1  high in RUN.
REQ-018 done  output  1  one-cycle pulse when map complete.

Function
REQ-019 FSM states IDLE, RUN; IDLE->RUN on cfg_start with cfg_len!=0; RUN->IDLE when word cfg_len-1 handshakes on output.
REQ-020 cfg_start with cfg_len==0 stays IDLE and pulses done next cycle.
REQ-021 cfg_* latched on accepted cfg_start; cfg_start while RUN ignored; changes to cfg_* during RUN have no effect.
REQ-022 Input beat transfers when vld&&rdy; output word transfers when vld&&rdy.
REQ-023 psum_acc2map_merger_rdy = RUN && (lane!=3 || !obuf_vld || obuf_rdy) && words_issued<cfg_len.
REQ-024 Per psum: s = psum + bias in 33-bit signed; if relu_en and s<0 then s=0; s >>>= shift (floor); saturate to [-128,127].
REQ-025 Lane counter 0..3 per beat; beat k writes bytes 2k (low psum) and 2k+1 (high psum); wraps 3->0.
REQ-026 Output vld asserted the cycle after the 4th beat is accepted; addr = base + 8*word_index; data/addr held stable until rdy.
REQ-027 Back-to-back: 4th beat of word n+1 may be accepted in the same cycle word n handshakes; no bubble required.
REQ-028 done pulses the cycle after the last output handshake; busy deasserts same cycle.
REQ-029 Input beats beyond cfg_len*4 not accepted (rdy low).

Reset
REQ-030 rst_n low: state IDLE, lane 0, word_index 0, all outputs 0 (rdy, vld, busy, done low; addr, data zero).
REQ-031 Reset mid-map abandons partial word and pending output without handshake.

Structure
REQ-032 Shared header map_merger_pkg holds state encodings, LANES=4, INT8_MAX/MIN constants.
REQ-033 One combinational sub-module map_merger_quant (bias, ReLU, shift, saturate) instantiated twice.

Verification
REQ-034 len=1, bias=0, shift=0, relu=0, beats {1,2},{3,4},{5,6},{7,8} -> one word 0x0807060504030201 at base, done pulse.
REQ-035 psum=-300, bias=44, relu=0, shift=1 -> -128 (0x80); relu=1 -> 0x00; psum=1000, shift=2 -> 127 (0x7F).
REQ-036 len=3, base=0x1000, obuf_rdy low 5 cycles on word 1 -> addrs 0x1000,0x1008,0x1010, data stable while stalled, input rdy low only for lane 3.
REQ-037 cfg_start with len=0 -> no output, done one cycle later, busy never high.
REQ-038 rst_n low after 2 beats of word 0 -> all outputs 0; new start produces correct first word.
REQ-039 cfg_start pulsed during RUN, and vld held after last beat -> ignored; rdy low after 4*len beats.
